// File: rtl/flash_audio_streamer_pkg.sv
// -----------------------------------------------------------------------------
// audio_stream_pkg
// Shared definitions for the flash-to-codec playback engine:
//   - state_e     : playback FSM states
//   - MODE_*      : playback speed encodings of the 2-bit mode input
//   - scale()     : signed arithmetic attenuation of one 16-bit sample
// -----------------------------------------------------------------------------
package audio_stream_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        WLOW = 3'd4,
        NEXT = 3'd5
    } state_e;

    // 2'b11 is treated as normal speed as well
    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FAST   = 2'b01;
    localparam logic [1:0] MODE_SLOW   = 2'b10;

    // Floor division by 2**shift with sign extension, so small negative
    // samples saturate at -1 rather than rounding towards zero.
    function automatic logic [15:0] scale(input logic [15:0] sample,
                                          input int unsigned shift);
        logic signed [15:0] s;
        s = $signed(sample);
        return 16'(s >>> shift);
    endfunction

endpackage

// File: rtl/flash_audio_streamer_codec_writer.sv
// -----------------------------------------------------------------------------
// codec_writer
// Owns the codec write handshake for one frame at a time. When frame_valid
// and write_ready are both seen, the frame is registered and write_s raised;
// write_s and the data are then held until write_ready is seen low, at which
// point write_s drops and frame_accepted pulses for the owning FSM.
//   clk, rst_n       : clock, asynchronous active-low reset
//   frame_valid      : a frame is offered (main FSM in WR)
//   frame_left/right : frame offered
//   write_ready      : codec FIFO can accept
//   frame_taken      : comb, handshake starts this cycle
//   frame_accepted   : comb, handshake completes this cycle
//   write_s          : registered codec write strobe
//   writedata_*      : registered frame data
// -----------------------------------------------------------------------------
module codec_writer
    import audio_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [15:0] frame_left,
    input  logic [15:0] frame_right,
    input  logic        write_ready,
    output logic        frame_taken,
    output logic        frame_accepted,
    output logic        write_s,
    output logic [15:0] writedata_left,
    output logic [15:0] writedata_right
);

    logic        write_s_q, write_s_d;
    logic [15:0] left_q, left_d;
    logic [15:0] right_q, right_d;

    // Handshake sequencing; write_s_q doubles as the "frame in flight" flag.
    always_comb begin
        write_s_d      = write_s_q;
        left_d         = left_q;
        right_d        = right_q;
        frame_taken    = 1'b0;
        frame_accepted = 1'b0;
        if (write_s_q) begin
            if (!write_ready) begin
                write_s_d      = 1'b0;
                frame_accepted = 1'b1;
            end else begin
                write_s_d = 1'b1;
            end
        end else begin
            if (frame_valid && write_ready) begin
                write_s_d   = 1'b1;
                left_d      = frame_left;
                right_d     = frame_right;
                frame_taken = 1'b1;
            end else begin
                write_s_d = 1'b0;
            end
        end
    end

    // Strobe and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_s_q <= 1'b0;
            left_q    <= 16'h0000;
            right_q   <= 16'h0000;
        end else begin
            write_s_q <= write_s_d;
            left_q    <= left_d;
            right_q   <= right_d;
        end
    end

    assign write_s         = write_s_q;
    assign writedata_left  = left_q;
    assign writedata_right = right_q;

endmodule

// File: rtl/flash_audio_streamer.sv
// -----------------------------------------------------------------------------
// flash_audio_streamer
// Fetches 32-bit words from flash over Avalon-MM in the window
// [START_ADDR, END_ADDR], splits each word into mono samples or a stereo
// frame, attenuates by VOL_SHIFT and hands frames to the codec writer.
// Normal, double and half speed are selected per word through mode.
//   clk, rst_n               : clock, asynchronous active-low reset
//   enable                   : play while high, stop at the next word boundary
//   mode                     : 00/11 normal, 01 double, 10 half speed
//   flash_mem_*              : Avalon-MM read master (one read outstanding)
//   write_ready / write_s    : codec handshake
//   writedata_left/right     : codec frame
//   busy                     : not idle
//   done                     : end of window (pulse if LOOP, sticky otherwise)
// -----------------------------------------------------------------------------
module flash_audio_streamer
    import audio_stream_pkg::*;
#(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned END_ADDR   = 1048575,
    parameter int unsigned VOL_SHIFT  = 6,
    parameter int unsigned STEREO     = 0,
    parameter int unsigned LOOP       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              flash_mem_read,
    input  logic              flash_mem_waitrequest,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    input  logic              write_ready,
    output logic              write_s,
    output logic [15:0]       writedata_left,
    output logic [15:0]       writedata_right,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   END_EXT = (ADDR_W + 1)'(END_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       s0_q, s0_d;
    logic [15:0]       s1_q, s1_d;
    logic [1:0]        idx_q, idx_d;

    logic              is_fast_s, is_slow_s;
    logic [1:0]        last_idx_s;
    logic              last_frame_s;
    logic [ADDR_W:0]   step_ext_s, next_ext_s;
    logic              word_last_s;
    logic [15:0]       frame_left_s, frame_right_s;
    logic              frame_valid_s, frame_taken_s, frame_accepted_s;

    assign is_fast_s = (mode_q == MODE_FAST);
    assign is_slow_s = (mode_q == MODE_SLOW);

    // Frames per word minus one, and which frame is presented next.
    always_comb begin
        last_idx_s    = 2'd0;
        frame_left_s  = s0_q;
        frame_right_s = s1_q;
        if (STEREO != 0) begin
            last_idx_s    = is_slow_s ? 2'd1 : 2'd0;
            frame_left_s  = s0_q;
            frame_right_s = s1_q;
        end else begin
            if (is_slow_s) begin
                last_idx_s = 2'd3;
            end else if (is_fast_s) begin
                last_idx_s = 2'd0;
            end else begin
                last_idx_s = 2'd1;
            end
            // Half speed repeats each sample, so the sample index is idx/2.
            if (is_slow_s ? idx_q[1] : idx_q[0]) begin
                frame_left_s  = s1_q;
                frame_right_s = s1_q;
            end else begin
                frame_left_s  = s0_q;
                frame_right_s = s0_q;
            end
        end
    end

    assign last_frame_s = (idx_q == last_idx_s);

    // Double speed skips a word; the window end is detected on the address
    // that would be fetched next, so a +2 step past END_ADDR also ends it.
    assign step_ext_s  = is_fast_s ? {{(ADDR_W - 1){1'b0}}, 2'b10}
                                   : {{ADDR_W{1'b0}}, 1'b1};
    assign next_ext_s  = {1'b0, addr_q} + step_ext_s;
    assign word_last_s = (next_ext_s > END_EXT);

    assign frame_valid_s = (state_q == WR) && enable;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A sticky done blocks restart until enable has been lowered.
                if (enable && !done_q) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (!flash_mem_waitrequest) begin
                    state_d = DATA;
                end else begin
                    state_d = REQ;
                end
            end
            DATA: begin
                if (flash_mem_readdatavalid) begin
                    state_d = WR;
                end else begin
                    state_d = DATA;
                end
            end
            WR: begin
                // Remaining frames of the word are dropped once enable falls.
                if (!enable) begin
                    state_d = NEXT;
                end else if (frame_taken_s) begin
                    state_d = WLOW;
                end else begin
                    state_d = WR;
                end
            end
            WLOW: begin
                if (frame_accepted_s) begin
                    state_d = last_frame_s ? NEXT : WR;
                end else begin
                    state_d = WLOW;
                end
            end
            NEXT: begin
                if (word_last_s) begin
                    state_d = ((LOOP != 0) && enable) ? REQ : IDLE;
                end else begin
                    state_d = enable ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values; every output is registered from these.
    always_comb begin
        addr_d = addr_q;
        mode_d = mode_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        idx_d  = idx_q;
        read_d = (state_d == REQ);
        busy_d = (state_d != IDLE);
        done_d = (LOOP != 0) ? 1'b0 : (done_q && enable);
        case (state_q)
            IDLE: begin
                addr_d = START_A;
            end
            REQ: begin
                mode_d = mode;
            end
            DATA: begin
                if (flash_mem_readdatavalid) begin
                    s0_d  = scale(flash_mem_readdata[15:0], VOL_SHIFT);
                    s1_d  = scale(flash_mem_readdata[31:16], VOL_SHIFT);
                    idx_d = 2'd0;
                end else begin
                    idx_d = idx_q;
                end
            end
            WLOW: begin
                if (frame_accepted_s && !last_frame_s) begin
                    idx_d = idx_q + 2'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            NEXT: begin
                if (word_last_s) begin
                    done_d = 1'b1;
                    addr_d = START_A;
                end else if (state_d == REQ) begin
                    addr_d = next_ext_s[ADDR_W-1:0];
                end else begin
                    addr_d = START_A;
                end
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= START_A;
            read_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mode_q <= MODE_NORMAL;
            s0_q   <= 16'h0000;
            s1_q   <= 16'h0000;
            idx_q  <= 2'd0;
        end else begin
            addr_q <= addr_d;
            read_q <= read_d;
            busy_q <= busy_d;
            done_q <= done_d;
            mode_q <= mode_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            idx_q  <= idx_d;
        end
    end

    codec_writer u_codec_writer (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_valid     (frame_valid_s),
        .frame_left      (frame_left_s),
        .frame_right     (frame_right_s),
        .write_ready     (write_ready),
        .frame_taken     (frame_taken_s),
        .frame_accepted  (frame_accepted_s),
        .write_s         (write_s),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right)
    );

    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = 4'b1111;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_flash_audio_streamer.sv
// -----------------------------------------------------------------------------
// tb_flash_audio_streamer
// Two streamer instances: [0] mono, VOL_SHIFT 6, window 0..3, looping;
// [1] stereo, VOL_SHIFT 0, window 16..17, one-shot. A flash model and a codec
// model serve both; expected codec frames are queued as stimulus is issued
// and popped by the codec model whenever a write is presented.
// -----------------------------------------------------------------------------
module tb_flash_audio_streamer;
    import audio_stream_pkg::*;

    typedef struct {
        int          inst;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]        en = 2'b00;
    logic [1:0][1:0]   mode = '0;
    logic [1:0]        rd;
    logic [1:0]        wreq = 2'b00;
    logic [1:0][22:0]  addr;
    logic [1:0][3:0]   be;
    logic [1:0][31:0]  rdata = '0;
    logic [1:0]        rdv = 2'b00;
    logic [1:0]        rdy = 2'b11;
    logic [1:0]        ws;
    logic [1:0][15:0]  wl;
    logic [1:0][15:0]  wr;
    logic [1:0]        busy;
    logic [1:0]        done;

    logic [31:0] mem [32];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt [2] = '{0, 0};
    int          rd_cnt [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          rcnt [2] = '{0, 0};
    int          stall_cfg = 0;
    int          stall_left [2] = '{0, 0};
    int          stall_seen = 0;
    logic        in_rd [2] = '{1'b0, 1'b0};
    logic        pend [2] = '{1'b0, 1'b0};
    logic [4:0]  paddr [2];
    logic [22:0] st_addr [2];

    always #5 clk = ~clk;

    flash_audio_streamer #(.ADDR_W(23), .START_ADDR(0), .END_ADDR(3), .VOL_SHIFT(6),
                           .STEREO(0), .LOOP(1)) u_mono (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .mode(mode[0]),
        .flash_mem_read(rd[0]), .flash_mem_waitrequest(wreq[0]),
        .flash_mem_address(addr[0]), .flash_mem_byteenable(be[0]),
        .flash_mem_readdata(rdata[0]), .flash_mem_readdatavalid(rdv[0]),
        .write_ready(rdy[0]), .write_s(ws[0]), .writedata_left(wl[0]),
        .writedata_right(wr[0]), .busy(busy[0]), .done(done[0]));

    flash_audio_streamer #(.ADDR_W(23), .START_ADDR(16), .END_ADDR(17), .VOL_SHIFT(0),
                           .STEREO(1), .LOOP(0)) u_stereo (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .mode(mode[1]),
        .flash_mem_read(rd[1]), .flash_mem_waitrequest(wreq[1]),
        .flash_mem_address(addr[1]), .flash_mem_byteenable(be[1]),
        .flash_mem_readdata(rdata[1]), .flash_mem_readdatavalid(rdv[1]),
        .write_ready(rdy[1]), .write_s(ws[1]), .writedata_left(wl[1]),
        .writedata_right(wr[1]), .busy(busy[1]), .done(done[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic push(input int inst, input logic [15:0] l, input logic [15:0] r);
        exp_t e;
        e.inst = inst;
        e.l    = l;
        e.r    = r;
        exp_q.push_back(e);
    endtask

    // Flash model: optional stall, one-cycle read latency, done pulse counting.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rdv[i] = 1'b0;
            if (pend[i]) begin
                rdv[i]   = 1'b1;
                rdata[i] = mem[paddr[i]];
                pend[i]  = 1'b0;
            end
            if (rd[i]) begin
                if (!in_rd[i]) begin
                    in_rd[i]      = 1'b1;
                    stall_left[i] = stall_cfg;
                    st_addr[i]    = addr[i];
                end
                if (stall_left[i] > 0) begin
                    wreq[i] = 1'b1;
                    stall_left[i]--;
                    stall_seen++;
                    check("stall_addr_stable", 32'(addr[i]), 32'(st_addr[i]));
                    check("stall_no_write", 32'(ws[i]), 32'd0);
                end else begin
                    wreq[i]  = 1'b0;
                    pend[i]  = 1'b1;
                    paddr[i] = addr[i][4:0];
                    in_rd[i] = 1'b0;
                    rd_cnt[i]++;
                end
            end else begin
                if (in_rd[i]) begin
                    check("read_held", 32'(rd[i]), 32'd1);
                end
                in_rd[i] = 1'b0;
                wreq[i]  = 1'b0;
            end
            if (done[i]) done_cnt[i]++;
        end
    end

    // Codec model and scoreboard monitor: take a frame, drop ready for 2 cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rdy[i]) begin
                if (rcnt[i] > 0) rcnt[i]--;
                if (rcnt[i] == 0) rdy[i] = 1'b1;
            end else if (ws[i]) begin
                rdy[i]  = 1'b0;
                rcnt[i] = 2;
                wr_cnt[i]++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(wl[i]), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("write_inst", i, e.inst);
                    check("write_left", 32'(wl[i]), 32'(e.l));
                    check("write_right", 32'(wr[i]), 32'(e.r));
                end
            end
        end
    end

    task automatic wait_writes(input int i, input int n);
        int t = 0;
        while (wr_cnt[i] != n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("write_count_reached", wr_cnt[i], n);
    endtask

    task automatic wait_idle(input int i);
        int t = 0;
        while (busy[i] !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 32'(busy[i]), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bw, br, bd, t;
        mem[0]  = 32'hC000_4000;
        mem[1]  = 32'hFFFF_FFC0;
        mem[2]  = 32'h7FFF_F03F;
        mem[3]  = 32'h8000_1234;
        mem[16] = 32'h8000_7FFF;
        mem[17] = 32'h1234_ABCD;
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_read0", 32'(rd[0]), 32'd0);
        check("rst_addr0", 32'(addr[0]), 32'd0);
        check("rst_addr1", 32'(addr[1]), 32'd16);
        check("rst_ws", 32'(ws), 32'd0);
        check("rst_wdata", 32'({wl[0], wr[0]}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mono normal, full pass then stop after first sample of pass two
        bw = wr_cnt[0]; br = rd_cnt[0]; bd = done_cnt[0];
        push(0, 16'h0100, 16'h0100); push(0, 16'hFF00, 16'hFF00);
        push(0, 16'hFFFF, 16'hFFFF); push(0, 16'hFFFF, 16'hFFFF);
        push(0, 16'hFFC0, 16'hFFC0); push(0, 16'h01FF, 16'h01FF);
        push(0, 16'h0048, 16'h0048); push(0, 16'hFE00, 16'hFE00);
        push(0, 16'h0100, 16'h0100);
        mode[0] = 2'b00;
        en[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_playing", 32'(busy[0]), 32'd1);
        wait_writes(0, bw + 9);
        en[0] = 1'b0;
        wait_idle(0);
        repeat (10) @(negedge clk);
        check("norm_writes", wr_cnt[0] - bw, 9);
        check("norm_reads", rd_cnt[0] - br, 5);
        check("norm_done", done_cnt[0] - bd, 1);
        check("norm_addr", 32'(addr[0]), 32'd0);
        check("norm_read_low", 32'(rd[0]), 32'd0);

        // Mono double speed: s0 of words 0 and 2, two passes
        bw = wr_cnt[0]; br = rd_cnt[0]; bd = done_cnt[0];
        push(0, 16'h0100, 16'h0100); push(0, 16'hFFC0, 16'hFFC0);
        push(0, 16'h0100, 16'h0100); push(0, 16'hFFC0, 16'hFFC0);
        mode[0] = 2'b01;
        en[0] = 1'b1;
        wait_writes(0, bw + 4);
        en[0] = 1'b0;
        wait_idle(0);
        repeat (10) @(negedge clk);
        check("fast_writes", wr_cnt[0] - bw, 4);
        check("fast_reads", rd_cnt[0] - br, 4);
        check("fast_done", done_cnt[0] - bd, 2);
        check("fast_addr", 32'(addr[0]), 32'd0);

        // Five-cycle waitrequest stall on the first read
        bw = wr_cnt[0]; br = rd_cnt[0]; stall_seen = 0;
        push(0, 16'h0100, 16'h0100); push(0, 16'hFF00, 16'hFF00);
        mode[0] = 2'b00;
        stall_cfg = 5;
        en[0] = 1'b1;
        t = 0;
        while (rd_cnt[0] == br && t < 200) begin
            @(negedge clk);
            t++;
        end
        stall_cfg = 0;
        check("stall_cycles", stall_seen, 5);
        wait_writes(0, bw + 2);
        en[0] = 1'b0;
        wait_idle(0);
        repeat (5) @(negedge clk);
        check("stall_reads", rd_cnt[0] - br, 1);

        // Reset pulse while a codec write is being held
        bw = wr_cnt[0]; br = rd_cnt[0];
        push(0, 16'h0100, 16'h0100);
        en[0] = 1'b1;
        t = 0;
        while (ws[0] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("wlow_reached", 32'(ws[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ws", 32'(ws[0]), 32'd0);
        check("arst_addr", 32'(addr[0]), 32'd0);
        check("arst_busy", 32'(busy[0]), 32'd0);
        check("arst_wdata", 32'(wl[0]), 32'd0);
        @(negedge clk);
        push(0, 16'h0100, 16'h0100); push(0, 16'hFF00, 16'hFF00);
        rst_n = 1'b1;
        wait_writes(0, bw + 3);
        en[0] = 1'b0;
        wait_idle(0);
        repeat (5) @(negedge clk);
        check("restart_reads", rd_cnt[0] - br, 2);

        // Stereo half speed, one-shot: sticky done, no restart while enabled
        bw = wr_cnt[1]; br = rd_cnt[1];
        push(1, 16'h7FFF, 16'h8000); push(1, 16'h7FFF, 16'h8000);
        push(1, 16'hABCD, 16'h1234); push(1, 16'hABCD, 16'h1234);
        mode[1] = 2'b10;
        en[1] = 1'b1;
        wait_writes(1, bw + 4);
        wait_idle(1);
        repeat (8) @(negedge clk);
        check("oneshot_done_sticky", 32'(done[1]), 32'd1);
        check("oneshot_busy", 32'(busy[1]), 32'd0);
        check("oneshot_reads", rd_cnt[1] - br, 2);
        check("oneshot_writes", wr_cnt[1] - bw, 4);
        check("oneshot_addr", 32'(addr[1]), 32'd16);
        en[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("oneshot_done_clear", 32'(done[1]), 32'd0);

        // Stereo double speed: one frame, +2 overshoots END_ADDR
        bw = wr_cnt[1]; br = rd_cnt[1];
        push(1, 16'h7FFF, 16'h8000);
        mode[1] = 2'b01;
        en[1] = 1'b1;
        wait_writes(1, bw + 1);
        wait_idle(1);
        repeat (5) @(negedge clk);
        check("sfast_done", 32'(done[1]), 32'd1);
        check("sfast_reads", rd_cnt[1] - br, 1);
        check("sfast_writes", wr_cnt[1] - bw, 1);
        en[1] = 1'b0;
        repeat (3) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_audio_streamer.md
# flash_audio_streamer

Parametrised flash-to-codec playback engine that sits between the flash Avalon-MM read port and the audio codec write port. It fetches 32-bit words from a configurable address window, unpacks them as mono sample pairs or stereo frames, and attenuates them by a configurable shift. It supports normal, double-speed and half-speed playback, with loop or one-shot termination. It replaces the fixed-function playback FSM in the top-level music design.

## Interface
- ADDR_W, 23, flash word-address width
- START_ADDR, 0, first word address played
- END_ADDR, 1048575, last word address played (inclusive); must be ≥ START_ADDR
- VOL_SHIFT, 6, arithmetic right-shift applied to every sample (0 = full scale)
- STEREO, 0, 0: word = two mono samples, [15:0] first then [31:16]; 1: word = one frame, left [15:0], right [31:16]
- LOOP, 1, 1: wrap to START_ADDR after END_ADDR; 0: stop after END_ADDR

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; high = play, low = stop at next frame boundary
- mode  in  2  00/11 normal, 01 double speed, 10 half speed; latched per flash word
- flash_mem_read  out  1  Avalon read request
- flash_mem_waitrequest  in  1  Avalon stall
- flash_mem_address  out  ADDR_W  word address
- flash_mem_byteenable  out  4  constant 4'b1111
- flash_mem_readdata  in  32  read data
- flash_mem_readdatavalid  in  1  read data valid
- write_ready  in  1  codec FIFO can accept
- write_s  out  1  codec write strobe
- writedata_left  out  16  left sample
- writedata_right  out  16  right sample
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on END_ADDR completion (LOOP=1); sticky until enable low (LOOP=0)

## Operation
- States: IDLE → REQ → DATA → WR → WLOW → (WR | NEXT) → REQ/IDLE.
- IDLE: leave when enable=1; address = START_ADDR.
- REQ: assert flash_mem_read; latch mode; advance to DATA on the first cycle waitrequest=0.
- DATA: read low; wait for readdatavalid; capture both halves, each scaled as signed >>> VOL_SHIFT (floor, sign-extended, so −1 → −1 and −64 → −1 at shift 6).
- WR: on write_ready=1, drive write_s=1 with the current frame. Mono: left=right=sample. Stereo: left=[15:0], right=[31:16].
- WLOW: hold write_s and data until write_ready=0, then drop write_s.
- Frame sequencing per word:
  - Mono normal: s0, s1.
  - Mono half speed: s0, s0, s1, s1.
  - Mono double speed: s0 only.
  - Stereo normal: frame once. Stereo half speed: frame twice.
  - Stereo double speed: frame once, then address += 2.
- NEXT: if address ≥ END_ADDR (including a +2 overshoot), pulse done and either wrap to START_ADDR (LOOP=1) or go to IDLE (LOOP=0). Otherwise increment and go to REQ, unless enable=0, in which case go to IDLE.
- enable low mid-word: the current codec handshake and any outstanding flash read always complete; the remaining frames of the word are discarded. Stop happens only at NEXT.
- mode change mid-word: takes effect at the next REQ.

## Timing
- Reset values: flash_mem_read 0, flash_mem_address START_ADDR, write_s 0, writedata 0, busy 0, done 0, state IDLE.
- All outputs are registered. flash_mem_read is high from the cycle after entry to REQ until the cycle after waitrequest=0 is sampled.
- Exactly one read is outstanding at a time; readdatavalid outside DATA is ignored.
- write_s rises one cycle after write_ready=1 is sampled in WR and falls one cycle after write_ready=0 is sampled.
- Minimum cost per frame: 2 cycles plus codec handshake. Minimum flash latency: 1 cycle after acceptance.
- Reset asserted mid-operation: every output returns to its reset value immediately.

## Structure
- Package audio_stream_pkg holds:
  - state enum (IDLE, REQ, DATA, WR, WLOW, NEXT)
  - mode constants (MODE_NORMAL, MODE_FAST, MODE_SLOW)
  - a scale function (signed >>> shift)
- Sub-module codec_writer owns the WR/WLOW handshake: input frame plus valid, output write_s and data, accepted pulse back to the main FSM.

## Test plan
- Mono normal, VOL_SHIFT=6, word 32'hC000_4000 → codec writes 16'h0100 then 16'hFF00 on both channels; address +1.
- Stereo, half speed, word 32'h8000_7FFF, VOL_SHIFT=0 → two frames of L=7FFF, R=8000.
- Double speed, START=0, END=3, LOOP=1, mono → exactly two writes per pass (s0 only), done pulses once per wrap, address returns to 0.
- waitrequest held high for 5 cycles → flash_mem_read stays high all 5 cycles, address stable, no codec write.
- LOOP=0, END_ADDR reached → done stays high and busy low until enable falls; enable dropped mid-word → current write completes, IDLE reached, no further reads.
- rst_n pulsed low during WLOW → write_s 0, address START_ADDR, busy 0 asynchronously; playback restarts cleanly.
